wb_queue: RTL
=============

Name: wb_queue

Overview:
- Writeback queue sitting between the MEM/WB stage and the register file's write port.
- Accepts completed results via a valid/ready handshake and buffers them in a small FIFO.
- Drains at most one register write per cycle, in order, onto write_enable/write_addr/write_data.
- Exposes a lookup port so decode can forward data from results still queued.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 5, register address width; matches register file address width.
- DATA_W, 32, register data width; matches register file data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  MEM/WB presents a result.
- in_ready  out  1  queue can accept; transfer occurs when in_valid && in_ready at posedge.
- in_addr  in  ADDR_W  destination register.
- in_data  in  DATA_W  result value.
- hold  in  1  suppresses draining while high.
- write_enable  out  1  register file write strobe.
- write_addr  out  ADDR_W  register file write address.
- write_data  out  DATA_W  register file write data.
- q_addr  in  ADDR_W  forwarding lookup address (decode read operand).
- q_hit  out  1  a queued entry targets q_addr.
- q_data  out  DATA_W  data of the youngest matching entry.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset: asynchronous on rst_n low.
  - Head pointer, tail pointer and count clear to 0; all entry valid bits clear.
  - write_enable=0, write_addr=0, write_data=0, q_hit=0, q_data=0, in_ready=1.
  - Any queued entries are discarded when reset is asserted mid-operation.
  - Outputs take their reset values while rst_n is low.
- in_ready = (count != DEPTH).
  - in_ready is independent of same-cycle drain: a full queue refuses input even while popping.
- Push: on posedge with in_valid && in_ready, store {in_addr, in_data} at tail; tail wraps modulo DEPTH.
- Drain, combinational from the head entry:
  - write_enable = (count != 0) && !hold.
  - write_addr and write_data show the head entry when count != 0, else 0.
  - On posedge with write_enable=1, the head advances (wraps modulo DEPTH).
- Latency: a result accepted at edge N is written to the register file at edge N+1 when hold=0.
- Throughput: 1 result per cycle with hold=0; the queue never exceeds 1 entry unless hold was asserted.
- Count updates:
  - push and pop in the same cycle: count unchanged.
  - push only: +1.
  - pop only: -1.
  - Count never exceeds DEPTH and never goes below 0.
- Ordering: strictly FIFO. Two entries to the same register drain oldest first.
- Forwarding lookup, combinational:
  - q_hit = 1 when q_addr != 0 and any stored entry has addr == q_addr.
  - q_data is the youngest such entry, searched from tail-1 back to head.
  - With no hit: q_hit=0, q_data=0.
  - The entry being drained this cycle still participates.
  - The in-flight in_data (not yet stored) does not participate.
- hold asserted mid-stream: draining freezes and entries are retained. Pushes continue until full; in_ready drops at count==DEPTH.
- Flush/jump does not affect the queue; queued results are committed state.

Optional Feature:
- Macro WB_X0_FILTER_EN.
- Defined: a push with in_addr==0 completes the handshake (in_ready honoured), but nothing is stored and count is unchanged.
- Undefined: x0 results are stored and drained like any other; the register file ignores the write.

Test Plan:
- Reset with rst_n=0 mid-stream holding 3 entries → count=0, write_enable=0, in_ready=1, q_hit=0, all asynchronously before the next clk edge.
- Push (x5, 0x0000_1234) with hold=0 → next cycle write_enable=1, write_addr=5, write_data=0x1234; the cycle after, count=0.
- hold=1 and push x1..x4 with data 0x11..0x44 → count=4, in_ready=0; a fifth push is refused. Release hold → writes x1,x2,x3,x4 on 4 consecutive cycles.
- hold=1, push (x7,0xA), (x7,0xB), q_addr=7 → q_hit=1, q_data=0xB. After release: first write 0xA, then 0xB, then q_hit=0.
- Count 4 with hold=0 and in_valid=1 → no acceptance that cycle; count=3 next cycle; accepted on the following cycle.
- Push (x0, 0xFF) → with WB_X0_FILTER_EN: count stays 0, no write. Without it: one write with write_addr=0. q_addr=0 gives q_hit=0 in both builds.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: writeback queue between MEM/WB and the register file write port.
//   Results enter through a valid/ready handshake, are buffered in a DEPTH-entry
//   FIFO and drain in order, at most one register write per cycle. A
//   combinational lookup port lets decode forward from results still queued.
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   in_valid/in_ready/in_addr/in_data  result input handshake
//   hold                             freezes draining while high
//   write_enable/addr/data           register file write port (from head entry)
//   q_addr -> q_hit/q_data           forwarding lookup, youngest match wins
//   count                            occupancy (0..DEPTH)
//
// Build option: define WB_X0_FILTER_EN to accept but discard results that
// target register x0 (handshake completes, nothing is stored).
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       hold,
  output logic                       write_enable,
  output logic [ADDR_W-1:0]          write_addr,
  output logic [DATA_W-1:0]          write_data,
  input  logic [ADDR_W-1:0]          q_addr,
  output logic                       q_hit,
  output logic [DATA_W-1:0]          q_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    head, tail, idx;
  logic [CW-1:0]    cnt;
  logic             push, store, pop;

  assign count        = cnt;
  // Full refuses input even if the head pops this cycle.
  assign in_ready     = (cnt != CW'(DEPTH));
  assign push         = in_valid && in_ready;
`ifdef WB_X0_FILTER_EN
  assign store        = push && (in_addr != '0);
`else
  assign store        = push;
`endif
  assign write_enable = (cnt != '0) && !hold;
  assign pop          = write_enable;
  assign write_addr   = (cnt != '0) ? mem[head].addr : '0;
  assign write_data   = (cnt != '0) ? mem[head].data : '0;

  // Entry payload needs no reset; occupancy is tracked by vld/cnt.
  always_ff @(posedge clk) begin
    if (store) mem[tail] <= '{addr: in_addr, data: in_data};
  end

  // store and pop never touch the same slot: that needs head==tail, which is
  // either empty (no pop) or full (no store).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      vld  <= '0;
    end else begin
      if (store) begin
        vld[tail] <= 1'b1;
        tail      <= tail + PW'(1);
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + PW'(1);
      end
      case ({store, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins. Occupied slots
  // are contiguous from head, so the valid bit alone bounds the search.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    idx    = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (vld[idx] && (q_addr != '0) && (mem[idx].addr == q_addr)) begin
        q_hit  = 1'b1;
        q_data = mem[idx].data;
      end
    end
  end
endmodule
